// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  localparam int              XLEN       = 32;
  localparam logic [XLEN-1:0] NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] FETCH_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// In-order queue of {pc, inst} entries with flush; a push is accepted when
// full provided a pop happens in the same cycle.
module ifetch_fifo #(
  parameter int          DEPTH   = 2,
  parameter int          W       = 64,
  parameter logic [W-1:0] RST_WORD = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = i_pop & (cnt_q != CW'(0));
  assign do_push = i_push & (~full | do_pop);
  assign o_rdata = mem_q[rd_q];
  assign o_count = cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_WORD;
    end else if (i_flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= i_wdata;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: sequential word fetch, in-order buffering, redirect
// flush with stale-response discard. Optional same-cycle bypass: IFETCH_BYPASS_EN.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_ren,
  output logic [31:0] o_imem_raddr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_vld,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_rdy,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_fetch_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_q,    state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q,  resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q,  discard_d;

  logic [CW-1:0] fifo_cnt;
  logic [63:0]   fifo_head;
  logic          accept;
  logic          keep;
  logic          byp;
  logic          pop;
  logic          fifo_push;
  logic          fifo_pop;

  // In-flight requests plus buffered words never exceed DEPTH, so a response
  // always finds room in the queue.
  assign o_imem_ren = (state_q == ST_RUN) & ~i_redirect & ~i_halt & ~i_rst &
                      (({1'b0, fifo_cnt} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
  assign o_imem_raddr = fetch_pc_q;
  assign accept       = o_imem_ren & i_imem_ready;
  assign keep         = i_imem_rvalid & ~i_redirect & (discard_q == CW'(0));
  assign o_fetch_err  = (state_q == ST_ERR);

`ifdef IFETCH_BYPASS_EN
  assign byp = keep & (fifo_cnt == CW'(0));
`else
  assign byp = 1'b0;
`endif

  assign o_inst_vld            = (fifo_cnt != CW'(0)) | byp;
  assign {o_inst_pc, o_inst}   = byp ? {resp_pc_q, i_imem_rdata} : fifo_head;
  assign pop                   = o_inst_vld & i_inst_rdy;
  assign fifo_push             = keep & ~(byp & i_inst_rdy);
  assign fifo_pop              = pop & ~byp;

  ifetch_fifo #(
    .DEPTH    (DEPTH),
    .W        (64),
    .RST_WORD ({32'h0000_0000, NOP})
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect),
    .i_push  (fifo_push),
    .i_wdata ({resp_pc_q, i_imem_rdata}),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_head),
    .o_count (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(accept) - CW'(i_imem_rvalid);
    if (i_redirect) begin
      state_d    = is_aligned(i_redirect_pc) ? ST_RUN : ST_ERR;
      fetch_pc_d = i_redirect_pc;
      resp_pc_d  = i_redirect_pc;
      // Everything still outstanding after this cycle belongs to the old path.
      discard_d  = inflight_q - CW'(i_imem_rvalid);
    end else begin
      if ((state_q == ST_RUN) && i_halt) state_d = ST_HALT;
      else                               state_d = state_q;
      if (accept) fetch_pc_d = fetch_pc_q + FETCH_STEP;
      else        fetch_pc_d = fetch_pc_q;
      if (keep) resp_pc_d = resp_pc_q + FETCH_STEP;
      else      resp_pc_d = resp_pc_q;
      if (i_imem_rvalid && (discard_q != CW'(0))) discard_d = discard_q - CW'(1);
      else                                        discard_d = discard_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_ADDR;
      resp_pc_q  <= RESET_ADDR;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch against a transaction-level model of memory,
// queue contents and the fetch state.
module tb_ifetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RA    = 32'h0000_0100;
  localparam logic [31:0] NOPW  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        o_imem_ren;
  logic [31:0] o_imem_raddr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_inst_vld;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_rdy;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_halt;
  logic        o_fetch_err;

  ifetch #(.RESET_ADDR(RA), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .o_imem_ren    (o_imem_ren),
    .o_imem_raddr  (o_imem_raddr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst_vld    (o_inst_vld),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .i_inst_rdy    (i_inst_rdy),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_halt        (i_halt),
    .o_fetch_err   (o_fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int cyc; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

  mreq_t       memq[$];
  ent_t        bufq[$];
  int          epoch, mstate, cyc, pops;
  logic [31:0] exp_faddr, exp_next;
  int          p_ready, p_rvalid, p_rdy;
  logic        do_redir, do_halt;
  logic [31:0] redir_pc;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    logic resp, keep, exp_vld, exp_ren, popped, byp_used;
    ent_t head;
    mreq_t e;
    @(negedge clk);
    cyc++;
    i_imem_ready  = ($urandom_range(99) < p_ready);
    i_inst_rdy    = ($urandom_range(99) < p_rdy);
    i_redirect    = do_redir;
    i_redirect_pc = redir_pc;
    i_halt        = do_halt;
    resp = (memq.size() > 0) && (memq[0].cyc < cyc) && ($urandom_range(99) < p_rvalid);
    i_imem_rvalid = resp;
    i_imem_rdata  = resp ? mem_word(memq[0].addr) : $urandom;
    #1;
    keep     = resp && !do_redir && (memq[0].epoch == epoch);
    byp_used = 1'b0;
    exp_vld  = bufq.size() > 0;
    head.pc = 32'h0; head.word = 32'h0;
    if (bufq.size() > 0) head = bufq[0];
`ifdef IFETCH_BYPASS_EN
    if (bufq.size() == 0 && keep) begin
      exp_vld = 1'b1; byp_used = 1'b1;
      head.pc = memq[0].addr; head.word = mem_word(memq[0].addr);
    end
`endif
    exp_ren = (mstate == 0) && !do_redir && !do_halt && ((bufq.size() + memq.size()) < DEPTH);
    check("ren", 32'(o_imem_ren), 32'(exp_ren));
    check("vld", 32'(o_inst_vld), 32'(exp_vld));
    check("err", 32'(o_fetch_err), 32'(mstate == 2));
    if (exp_vld) begin
      check("inst", o_inst, head.word);
      check("pc", o_inst_pc, head.pc);
    end
    if (o_imem_ren && i_imem_ready) check("raddr", o_imem_raddr, exp_faddr);

    popped = exp_vld && i_inst_rdy;
    if (popped) begin
      if (!do_redir) begin
        check("order", head.pc, exp_next);
        exp_next += 32'd4;
      end
      pops++;
      if (!byp_used) void'(bufq.pop_front());
    end
    if (resp) begin
      e = memq.pop_front();
      if (keep && !(byp_used && popped)) begin
        check("no_push_full", 32'(bufq.size() < DEPTH), 32'd1);
        bufq.push_back('{pc: e.addr, word: mem_word(e.addr)});
      end
    end
    if (o_imem_ren && i_imem_ready) begin
      memq.push_back('{addr: o_imem_raddr, epoch: epoch, cyc: cyc});
      exp_faddr += 32'd4;
      check("inflight", 32'(memq.size() <= DEPTH), 32'd1);
    end
    if (do_redir) begin
      epoch++;
      bufq.delete();
      mstate    = (redir_pc[1:0] == 2'b00) ? 0 : 2;
      exp_faddr = redir_pc;
      exp_next  = redir_pc;
    end else if (mstate == 0 && do_halt) begin
      mstate = 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect(input logic [31:0] pc);
    do_redir = 1'b1; redir_pc = pc;
    step();
    do_redir = 1'b0;
  endtask

  initial begin
    int guard;
    cyc = 0; pops = 0; epoch = 0; mstate = 0;
    do_redir = 1'b0; do_halt = 1'b0; redir_pc = 32'h0;
    p_ready = 100; p_rvalid = 100; p_rdy = 100;
    i_rst = 1'b1; i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    i_inst_rdy = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0; i_halt = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ren", 32'(o_imem_ren), 32'd0);
    check("rst_raddr", o_imem_raddr, RA);
    check("rst_vld", 32'(o_inst_vld), 32'd0);
    check("rst_inst", o_inst, NOPW);
    check("rst_pc", o_inst_pc, 32'h0);
    check("rst_err", 32'(o_fetch_err), 32'd0);
    exp_faddr = RA; exp_next = RA;
    i_rst = 1'b0;

    // Zero-wait streaming from reset address.
    run(20);
    // Decode stall, then release.
    p_rdy = 0;   run(10);
    p_rdy = 100; run(10);

    // Two requests outstanding, redirect drops both.
    p_rvalid = 0; guard = 0;
    while (memq.size() < 2 && guard < 20) begin step(); guard++; end
    check("two_inflight", 32'(memq.size()), 32'd2);
    redirect(32'h0000_0200);
    p_rvalid = 100; run(10);

    // Halt with one outstanding, drain, then resume elsewhere.
    p_rvalid = 0; p_rdy = 0; guard = 0;
    while (memq.size() < 1 && guard < 20) begin step(); guard++; end
    check("one_inflight", 32'(memq.size() >= 1), 32'd1);
    do_halt = 1'b1; step(); do_halt = 1'b0;
    p_rvalid = 100; p_rdy = 100; run(8);
    check("halted", 32'(mstate), 32'd1);
    redirect(32'h0000_0040);
    run(8);

    // Misaligned target, then recovery.
    redirect(32'h0000_0202);
    run(5);
    redirect(32'h0000_0300);
    run(8);

    // Wrap at the top of the address space.
    redirect(32'hFFFF_FFF8);
    run(8);

    // Random traffic.
    p_ready = 70; p_rvalid = 60; p_rdy = 70;
    pops = 0; guard = 0;
    while (pops < 1000 && guard < 20000) begin
      guard++;
      if (mstate != 0 && $urandom_range(99) < 5) begin
        redirect({$urandom_range(32'hFFFF) , 2'b00});
      end else if ($urandom_range(999) < 10) begin
        redirect({$urandom, 2'b00} & 32'hFFFF_FFFC);
      end else if ($urandom_range(999) < 3) begin
        redirect(32'h0000_1001);
      end else if ($urandom_range(999) < 5) begin
        do_halt = 1'b1; step(); do_halt = 1'b0;
      end else begin
        step();
      end
    end
    check("random_pops", 32'(pops >= 1000), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
